// File: rtl/wb_pkg.sv
// Shared widths and the queue entry type for the writeback queue and its
// forwarding search.
package wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Parallel search of the live queue entries for a register address.
// Reports the youngest matching entry.
import wb_pkg::*;

module wb_fwd_match #(
   parameter int DEPTH = 4
) (
   input  wb_entry_t                    entries [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]     head,
   input  logic [$clog2(DEPTH+1)-1:0]   count,
   input  logic [REG_ADDR_W-1:0]        lookup,
   output logic                         hit,
   output logic [DATA_W-1:0]            data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] match;
   logic [DATA_W-1:0] slot_data [DEPTH];

   // Slot gi is the gi-th oldest entry; it is live only when gi < count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] idx;
      assign idx           = head + PW'(gi);
      assign match[gi]     = (CW'(gi) < count) && (entries[idx].addr == lookup);
      assign slot_data[gi] = entries[idx].data;
   end

   // Younger slots come later in the scan and override older matches.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      if (lookup != '0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
               hit  = 1'b1;
               data = slot_data[i];
            end
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// Merges MEM and ALU results into an in-order register-file write stream,
// one write per cycle, with forwarding of pending results.
import wb_pkg::*;

module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          MEM_Valid,
   input  logic [REG_ADDR_W-1:0]         MEM_Register,
   input  logic [DATA_W-1:0]             MEM_Data,
   output logic                          MEM_Ready,
   input  logic                          ALU_Valid,
   input  logic [REG_ADDR_W-1:0]         ALU_Register,
   input  logic [DATA_W-1:0]             ALU_Data,
   output logic                          ALU_Ready,
   output logic [REG_ADDR_W-1:0]         Write_Register,
   output logic [DATA_W-1:0]             Write_Data,
   output logic                          RegWrite,
   input  logic [REG_ADDR_W-1:0]         Lookup_Register_1,
   input  logic [REG_ADDR_W-1:0]         Lookup_Register_2,
   output logic                          Fwd_Hit_1,
   output logic                          Fwd_Hit_2,
   output logic [DATA_W-1:0]             Fwd_Data_1,
   output logic [DATA_W-1:0]             Fwd_Data_2,
   output logic [$clog2(DEPTH+1)-1:0]    Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   wb_entry_t     entries_reg [DEPTH];
   logic [PW-1:0] head_reg;
   logic [PW-1:0] tail_reg;
   logic [CW-1:0] count_reg;

   logic [CW-1:0] free_slots;
   logic          mem_push;
   logic          alu_push;
   logic          pop;
   logic [PW-1:0] alu_slot;
   logic          hit_1;
   logic          hit_2;
   logic [DATA_W-1:0] data_1;
   logic [DATA_W-1:0] data_2;

   // Readiness looks only at the registered occupancy; a same-cycle pop
   // never frees a slot for a push.
   assign free_slots = CW'(DEPTH) - count_reg;
   assign MEM_Ready  = RST_N && (count_reg < CW'(DEPTH));
   assign ALU_Ready  = RST_N && ((free_slots >= CW'(2)) ||
                                 ((count_reg < CW'(DEPTH)) && !MEM_Valid));

   // Writes to r0 complete the handshake but are dropped.
   assign mem_push = MEM_Valid && MEM_Ready && (MEM_Register != '0);
   assign alu_push = ALU_Valid && ALU_Ready && (ALU_Register != '0);
   assign alu_slot = tail_reg + PW'(mem_push);

   assign RegWrite       = RST_N && (count_reg != '0);
   assign pop            = RegWrite;
   assign Write_Register = RegWrite ? entries_reg[head_reg].addr : '0;
   assign Write_Data     = RegWrite ? entries_reg[head_reg].data : '0;
   assign Count          = count_reg;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (pop) begin
            head_reg <= head_reg + PW'(1);
         end
         tail_reg  <= tail_reg + PW'(mem_push) + PW'(alu_push);
         count_reg <= count_reg - CW'(pop) + CW'(mem_push) + CW'(alu_push);
      end
   end

   // Payload flops need no reset: occupancy alone decides what is live.
   always_ff @(posedge CLK) begin
      if (mem_push) begin
         entries_reg[tail_reg] <= '{addr: MEM_Register, data: MEM_Data};
      end
      if (alu_push) begin
         entries_reg[alu_slot] <= '{addr: ALU_Register, data: ALU_Data};
      end
   end

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_1 (
      .entries (entries_reg),
      .head    (head_reg),
      .count   (count_reg),
      .lookup  (Lookup_Register_1),
      .hit     (hit_1),
      .data    (data_1)
   );

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_2 (
      .entries (entries_reg),
      .head    (head_reg),
      .count   (count_reg),
      .lookup  (Lookup_Register_2),
      .hit     (hit_2),
      .data    (data_2)
   );

   assign Fwd_Hit_1  = RST_N && hit_1;
   assign Fwd_Hit_2  = RST_N && hit_2;
   assign Fwd_Data_1 = RST_N ? data_1 : '0;
   assign Fwd_Data_2 = RST_N ? data_2 : '0;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: handshakes, ordering, forwarding,
// r0 drop, reset mid-drain and pointer wrap against hand-computed values.
module tb_writeback_queue;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        MEM_Valid, ALU_Valid;
   logic [4:0]  MEM_Register, ALU_Register;
   logic [31:0] MEM_Data, ALU_Data;
   logic        MEM_Ready, ALU_Ready;
   logic [4:0]  Write_Register;
   logic [31:0] Write_Data;
   logic        RegWrite;
   logic [4:0]  Lookup_Register_1, Lookup_Register_2;
   logic        Fwd_Hit_1, Fwd_Hit_2;
   logic [31:0] Fwd_Data_1, Fwd_Data_2;
   logic [2:0]  Count;

   int n_cmp = 0;
   int n_err = 0;

   logic [36:0] wlog [$];
   logic [31:0] rf [32];

   always #5 CLK = ~CLK;

   writeback_queue #(.DEPTH(4)) dut (
      .CLK               (CLK),
      .RST_N             (RST_N),
      .MEM_Valid         (MEM_Valid),
      .MEM_Register      (MEM_Register),
      .MEM_Data          (MEM_Data),
      .MEM_Ready         (MEM_Ready),
      .ALU_Valid         (ALU_Valid),
      .ALU_Register      (ALU_Register),
      .ALU_Data          (ALU_Data),
      .ALU_Ready         (ALU_Ready),
      .Write_Register    (Write_Register),
      .Write_Data        (Write_Data),
      .RegWrite          (RegWrite),
      .Lookup_Register_1 (Lookup_Register_1),
      .Lookup_Register_2 (Lookup_Register_2),
      .Fwd_Hit_1         (Fwd_Hit_1),
      .Fwd_Hit_2         (Fwd_Hit_2),
      .Fwd_Data_1        (Fwd_Data_1),
      .Fwd_Data_2        (Fwd_Data_2),
      .Count             (Count)
   );

   // Register-file side: every write consumed at the edge, in order.
   always @(posedge CLK) begin
      if (RegWrite === 1'b1) begin
         wlog.push_back({Write_Register, Write_Data});
         rf[Write_Register] = Write_Data;
         $display("write x%0d <= 0x%08h", Write_Register, Write_Data);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      MEM_Valid = 1'b0; MEM_Register = '0; MEM_Data = '0;
      ALU_Valid = 1'b0; ALU_Register = '0; ALU_Data = '0;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 10 && Count != 0; k++) tick();
      check(tag, 32'(Count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Expected write order for the saturation run (MEM older than ALU).
   logic [4:0]  sat_reg  [8] = '{5'd1, 5'd16, 5'd2, 5'd17, 5'd3, 5'd4, 5'd5, 5'd6};
   logic [31:0] sat_data [8] = '{32'h100, 32'h200, 32'h101, 32'h201,
                                 32'h102, 32'h103, 32'h104, 32'h105};
   logic [2:0]  sat_cnt  [6] = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
   logic        sat_ar   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      int mi, ai;
      logic mf, af;

      RST_N = 1'b0;
      idle_inputs();
      Lookup_Register_1 = '0;
      Lookup_Register_2 = '0;
      for (int i = 0; i < 32; i++) rf[i] = '0;

      // Reset behaviour
      tick(); tick();
      check("rst_count", 32'(Count), 32'd0);
      check("rst_mem_ready", 32'(MEM_Ready), 32'd0);
      check("rst_alu_ready", 32'(ALU_Ready), 32'd0);
      check("rst_regwrite", 32'(RegWrite), 32'd0);
      RST_N = 1'b1;
      #1;
      check("rel_count", 32'(Count), 32'd0);
      check("rel_regwrite", 32'(RegWrite), 32'd0);
      check("rel_mem_ready", 32'(MEM_Ready), 32'd1);
      check("rel_alu_ready", 32'(ALU_Ready), 32'd1);

      // Single MEM result: presented next cycle, popped after one edge
      wlog.delete();
      MEM_Valid = 1'b1; MEM_Register = 5'd8; MEM_Data = 32'h1234;
      #1;
      check("single_mem_ready", 32'(MEM_Ready), 32'd1);
      tick();
      idle_inputs();
      #1;
      check("single_count1", 32'(Count), 32'd1);
      check("single_regwrite", 32'(RegWrite), 32'd1);
      check("single_wreg", 32'(Write_Register), 32'd8);
      check("single_wdata", Write_Data, 32'h1234);
      tick();
      check("single_count0", 32'(Count), 32'd0);
      check("single_regwrite0", 32'(RegWrite), 32'd0);
      check("single_nwrites", 32'(wlog.size()), 32'd1);

      // Same-cycle MEM and ALU to the same register
      wlog.delete();
      MEM_Valid = 1'b1; MEM_Register = 5'd3; MEM_Data = 32'hA;
      ALU_Valid = 1'b1; ALU_Register = 5'd3; ALU_Data = 32'hB;
      Lookup_Register_1 = 5'd3;
      Lookup_Register_2 = 5'd5;
      #1;
      check("dual_alu_ready", 32'(ALU_Ready), 32'd1);
      check("dual_fwd_not_incoming", 32'(Fwd_Hit_1), 32'd0);
      tick();
      idle_inputs();
      #1;
      check("dual_count", 32'(Count), 32'd2);
      check("dual_head_data", Write_Data, 32'hA);
      check("dual_fwd_hit1", 32'(Fwd_Hit_1), 32'd1);
      check("dual_fwd_data1", Fwd_Data_1, 32'hB);
      check("dual_fwd_hit2", 32'(Fwd_Hit_2), 32'd0);
      tick();
      check("dual_second_data", Write_Data, 32'hB);
      check("dual_fwd_data1_after", Fwd_Data_1, 32'hB);
      tick();
      check("dual_fwd_hit1_empty", 32'(Fwd_Hit_1), 32'd0);
      check("dual_nwrites", 32'(wlog.size()), 32'd2);
      check("dual_w0", wlog[0][31:0], 32'hA);
      check("dual_w1", wlog[1][31:0], 32'hB);
      Lookup_Register_1 = '0;
      Lookup_Register_2 = '0;

      // Both producers saturating the queue for 6 cycles
      wlog.delete();
      mi = 0; ai = 0;
      MEM_Valid = 1'b1; ALU_Valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         MEM_Register = 5'(mi + 1);  MEM_Data = 32'h100 + 32'(mi);
         ALU_Register = 5'(ai + 16); ALU_Data = 32'h200 + 32'(ai);
         #1;
         check($sformatf("sat_count_c%0d", c), 32'(Count), 32'(sat_cnt[c]));
         check($sformatf("sat_alu_ready_c%0d", c), 32'(ALU_Ready), 32'(sat_ar[c]));
         check($sformatf("sat_mem_ready_c%0d", c), 32'(MEM_Ready), 32'd1);
         mf = MEM_Ready; af = ALU_Ready;
         tick();
         if (mf) mi++;
         if (af) ai++;
      end
      idle_inputs();
      drain("sat_drain");
      check("sat_nwrites", 32'(wlog.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("sat_reg_%0d", i), 32'(wlog[i][36:32]), 32'(sat_reg[i]));
         check($sformatf("sat_data_%0d", i), wlog[i][31:0], sat_data[i]);
      end

      // Write to r0 is accepted but dropped
      wlog.delete();
      ALU_Valid = 1'b1; ALU_Register = 5'd0; ALU_Data = 32'hFFFF;
      Lookup_Register_1 = 5'd0;
      #1;
      check("r0_alu_ready", 32'(ALU_Ready), 32'd1);
      tick();
      idle_inputs();
      #1;
      check("r0_count", 32'(Count), 32'd0);
      check("r0_regwrite", 32'(RegWrite), 32'd0);
      check("r0_fwd_hit", 32'(Fwd_Hit_1), 32'd0);
      tick();
      check("r0_nwrites", 32'(wlog.size()), 32'd0);

      // Reset while three entries are pending
      wlog.delete();
      MEM_Valid = 1'b1; MEM_Register = 5'd4; MEM_Data = 32'h44;
      ALU_Valid = 1'b1; ALU_Register = 5'd5; ALU_Data = 32'h55;
      tick();
      MEM_Register = 5'd6; MEM_Data = 32'h66;
      ALU_Register = 5'd7; ALU_Data = 32'h77;
      tick();
      idle_inputs();
      Lookup_Register_1 = 5'd6;
      #1;
      check("mid_count", 32'(Count), 32'd3);
      check("mid_fwd_data", Fwd_Data_1, 32'h66);
      RST_N = 1'b0;
      #1;
      check("mid_rst_mem_ready", 32'(MEM_Ready), 32'd0);
      check("mid_rst_alu_ready", 32'(ALU_Ready), 32'd0);
      check("mid_rst_regwrite", 32'(RegWrite), 32'd0);
      check("mid_rst_fwd_hit", 32'(Fwd_Hit_1), 32'd0);
      tick();
      check("mid_rst_count", 32'(Count), 32'd0);
      RST_N = 1'b1;
      #1;
      check("mid_rel_mem_ready", 32'(MEM_Ready), 32'd1);
      check("mid_rel_alu_ready", 32'(ALU_Ready), 32'd1);
      check("mid_rel_regwrite", 32'(RegWrite), 32'd0);
      check("mid_rel_fwd_hit", 32'(Fwd_Hit_1), 32'd0);
      tick(); tick();
      check("mid_nwrites", 32'(wlog.size()), 32'd1);
      check("mid_only_write", 32'(wlog[0][36:32]), 32'd4);
      Lookup_Register_1 = '0;

      // Ten single writes across the pointer wrap
      wlog.delete();
      for (int i = 0; i < 32; i++) rf[i] = '0;
      for (int r = 1; r <= 10; r++) begin
         idle_inputs();
         if (r % 2 == 1) begin
            MEM_Valid = 1'b1; MEM_Register = 5'(r); MEM_Data = 32'(r) * 32'h11;
         end else begin
            ALU_Valid = 1'b1; ALU_Register = 5'(r); ALU_Data = 32'(r) * 32'h11;
         end
         #1;
         check($sformatf("wrap_ready_%0d", r),
               32'((r % 2 == 1) ? MEM_Ready : ALU_Ready), 32'd1);
         tick();
      end
      idle_inputs();
      drain("wrap_drain");
      check("wrap_nwrites", 32'(wlog.size()), 32'd10);
      for (int r = 1; r <= 10; r++) begin
         check($sformatf("wrap_rf_x%0d", r), rf[r], 32'(r) * 32'h11);
      end
      check("wrap_rf_x11", rf[11], 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of pending write entries (power of two, 2..16).
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on posedge CLK.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port MEM_Valid  input  1  load result offered.
REQ-005 SHALL have port MEM_Register  input  5  load destination register.
REQ-006 SHALL have port MEM_Data  input  32  load data.
REQ-007 SHALL have port MEM_Ready  output  1  load result accepted this cycle when high with MEM_Valid.
REQ-008 SHALL have ports ALU_Valid, ALU_Register, ALU_Data, ALU_Ready with the same widths and roles for ALU results.
REQ-009 SHALL have port Write_Register  output  5  register-file write address.
REQ-010 SHALL have port Write_Data  output  32  register-file write data.
REQ-011 SHALL have port RegWrite  output  1  register-file write enable, consumed at posedge CLK.
REQ-012 SHALL have ports Lookup_Register_1, Lookup_Register_2  input  5  forwarding query addresses.
REQ-013 SHALL have ports Fwd_Hit_1, Fwd_Hit_2  output  1  and Fwd_Data_1, Fwd_Data_2  output  32  forwarding results.
REQ-014 SHALL have port Count  output  $clog2(DEPTH+1)  number of queued entries.

Function
REQ-015 SHALL hold entries in a circular FIFO (head/tail pointers wrap modulo DEPTH, Count 0..DEPTH).
REQ-016 SHALL compute readiness from registered Count only (no same-cycle pop credit): MEM_Ready = Count<DEPTH; ALU_Ready = (DEPTH-Count>=2) or (Count<DEPTH and !MEM_Valid).
REQ-017 SHALL, when both handshakes fire in one cycle, enqueue MEM first then ALU (program order: MEM older).
REQ-018 SHALL complete the handshake for an entry whose register is 0 but not enqueue it (Count unchanged by that entry).
REQ-019 SHALL drive RegWrite=1 combinationally whenever Count>0, with Write_Register/Write_Data equal to the head entry; RegWrite=0, Write_Register=0, Write_Data=0 when empty.
REQ-020 SHALL pop the head at every posedge CLK where RegWrite=1: exactly one register-file write per cycle.
REQ-021 SHALL give latency: entry accepted at edge N into an empty queue is presented in cycle N..N+1 and written at edge N+1.
REQ-022 SHALL handle simultaneous pop and push(es) in one edge: Count_next = Count - pop + pushes; push into a full queue is impossible by REQ-016.
REQ-023 SHALL assert Fwd_Hit_x when Lookup_Register_x!=0 and any queued entry matches it; Fwd_Data_x SHALL be the youngest matching entry's data, else 0.
REQ-024 SHALL exclude same-cycle incoming (not yet enqueued) results from forwarding.
REQ-025 SHALL keep duplicate destinations as separate entries written in order (the last write wins in the register file).

Reset
REQ-026 SHALL, on posedge CLK with RST_N=0, clear head, tail, Count to 0 and discard all pending entries, including mid-drain.
REQ-027 SHALL force MEM_Ready=0, ALU_Ready=0, RegWrite=0, Fwd_Hit_1/2=0 while RST_N=0.
REQ-028 SHALL present, in the first cycle after reset release, Count=0, RegWrite=0, MEM_Ready=1, ALU_Ready=1.

Structure
REQ-029 SHALL take REG_ADDR_W=5, DATA_W=32 and typedef wb_entry_t {reg addr, data} from shared package wb_pkg.
REQ-030 SHALL implement forwarding search in sub-module wb_fwd_match (queue contents + head/Count + lookup address -> hit/data), instantiated twice.
REQ-031 SHALL store entry data in flops (no RAM inference) so forwarding reads all entries in parallel.

Verification
REQ-032 Bench SHALL check: reset, MEM_Valid=1 reg 8 data 0x1234 -> RegWrite=1, Write_Register=8, Write_Data=0x1234 next cycle, Count 1->0 after one edge.
REQ-033 Bench SHALL check: MEM(reg 3, 0xA) and ALU(reg 3, 0xB) same cycle -> writes in order 0xA then 0xB; Lookup_Register_1=3 after enqueue -> Fwd_Hit_1=1, Fwd_Data_1=0xB.
REQ-034 Bench SHALL check: MEM_Valid and ALU_Valid held high with distinct regs for 6 cycles, DEPTH=4 -> Count never exceeds 4, ALU_Ready=0 whenever free slots <2, no entry lost or reordered.
REQ-035 Bench SHALL check: ALU write to reg 0 data 0xFFFF -> ALU_Ready=1, Count stays 0, RegWrite stays 0; Lookup 0 -> Fwd_Hit=0.
REQ-036 Bench SHALL check: queue holding 3 entries, RST_N=0 one cycle -> Count=0, RegWrite=0, readies 0 during reset, 1 after, no stale writes.
REQ-037 Bench SHALL check: pointer wrap after 10 sequential single writes (regs 1..10, data = reg*0x11) -> register-file model matches exactly.
